// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

   localparam logic [15:0] NOP_OP           = 16'h0000;
   localparam int unsigned DEFAULT_RESET_PC = 32'd0;

endpackage

// File: rtl/fetch_timer.sv
// Clearable, enabled down-counter; expired is high on the TIMEOUT-th enabled cycle.
module fetch_timer
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   // Load the full budget on clear, then count down while enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= CW'(TIMEOUT);
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign expired = en && (r_cnt == CW'(1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction fetch handshake, IR and zero flag for the
// microcoded controller.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned IR_W     = 16,
   parameter int unsigned RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              pc_ld,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              z_ld,
   input  logic              alu_zero,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [IR_W-1:0]   mem_rdata,
   output logic [IR_W-1:0]   IR,
   output logic              z,
   output logic              ir_valid,
   output logic              busy,
   output logic              err
);

   fetch_state_e      r_state;
   fetch_state_e      w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_addr;
   logic [IR_W-1:0]   r_ir;
   logic [ADDR_W-1:0] r_pend_tgt;
   logic              r_pend_vld;
   logic              r_req;
   logic              r_ir_valid;
   logic              r_err;
   logic              r_z;
   logic              w_start;
   logic              w_done;
   logic              w_expired;
   logic              w_pend_vld;
   logic [ADDR_W-1:0] w_pend_tgt;

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (w_start),
      .en      (r_state == S_WAIT),
      .expired (w_expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; a pc_ld on the completing edge is the latest jump.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_done       = 1'b0;
      w_pend_vld   = r_pend_vld;
      w_pend_tgt   = r_pend_tgt;
      case (r_state)
         S_IDLE: begin
            if (fetch_en) begin
               w_start      = 1'b1;
               w_next_state = S_WAIT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_WAIT: begin
            if (pc_ld) begin
               w_pend_vld = 1'b1;
               w_pend_tgt = jump_target;
            end else begin
               w_pend_vld = r_pend_vld;
            end
            if (mem_ready || w_expired) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath registers: request, PC, IR, pending jump, flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= ADDR_W'(RESET_PC);
         r_addr     <= '0;
         r_ir       <= '0;
         r_req      <= 1'b0;
         r_ir_valid <= 1'b0;
         r_err      <= 1'b0;
         r_z        <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_ir_valid <= 1'b0;
         if (z_ld) begin
            r_z <= alu_zero;
         end
         if (w_start) begin
            r_req      <= 1'b1;
            r_addr     <= pc_ld ? jump_target : r_pc;
            r_pend_vld <= 1'b0;
         end else if (w_done) begin
            r_req      <= 1'b0;
            r_ir_valid <= 1'b1;
            r_pend_vld <= 1'b0;
            if (mem_ready) begin
               r_ir <= mem_rdata;
               r_pc <= w_pend_vld ? w_pend_tgt : (r_addr + ADDR_W'(1));
            end else begin
               r_ir  <= IR_W'(NOP_OP);
               r_err <= 1'b1;
               r_pc  <= w_pend_vld ? w_pend_tgt : r_pc;
            end
         end else if (r_state == S_WAIT) begin
            r_pend_vld <= w_pend_vld;
            r_pend_tgt <= w_pend_tgt;
         end else if (pc_ld) begin
            r_pc <= jump_target;
         end
      end
   end

   assign mem_req  = r_req;
   assign mem_addr = r_addr;
   assign IR       = r_ir;
   assign z        = r_z;
   assign ir_valid = r_ir_valid;
   assign err      = r_err;
   assign busy     = (r_state == S_WAIT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with hand sequences for
// timeout and reset-during-fetch.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        pc_ld;
   logic [15:0] jump_target;
   logic        z_ld;
   logic        alu_zero;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] IR;
   logic        z;
   logic        ir_valid;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(16), .IR_W(16), .RESET_PC(0), .TIMEOUT(15)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_en    (fetch_en),
      .pc_ld       (pc_ld),
      .jump_target (jump_target),
      .z_ld        (z_ld),
      .alu_zero    (alu_zero),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .IR          (IR),
      .z           (z),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .err         (err)
   );

   typedef struct {
      logic        rst;
      logic        fe;
      logic        pl;
      logic [15:0] jt;
      logic        zl;
      logic        az;
      logic        rdy;
      logic [15:0] rd;
      logic        e_req;
      logic [15:0] e_addr;
      logic [15:0] e_ir;
      logic        e_vld;
      logic        e_busy;
      logic        e_err;
      logic        e_z;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic fe, input logic pl, input logic [15:0] jt,
                        input logic rdy, input logic [15:0] rd);
      reset       = rst;
      fetch_en    = fe;
      pc_ld       = pl;
      jump_target = jt;
      mem_ready   = rdy;
      mem_rdata   = rd;
      z_ld        = 1'b0;
      alu_zero    = 1'b0;
   endtask

   int hi_cnt;

   initial begin
      //          rst   fe    pl    jt        zl    az    rdy   rd         req   addr      ir        vld   busy  err   z
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0001, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0F0F, 1'b0, 16'h0041, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h0100, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0100, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 16'hFFFF, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 16'h0000, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b1, 16'h0001, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 16'h0001, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b0};

      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();

      for (int i = 0; i < 23; i++) begin
         reset       = vecs[i].rst;
         fetch_en    = vecs[i].fe;
         pc_ld       = vecs[i].pl;
         jump_target = vecs[i].jt;
         z_ld        = vecs[i].zl;
         alu_zero    = vecs[i].az;
         mem_ready   = vecs[i].rdy;
         mem_rdata   = vecs[i].rd;
         step();
         chk($sformatf("v%0d mem_req", i),  {31'd0, mem_req},  {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].e_addr});
         chk($sformatf("v%0d IR", i),       {16'd0, IR},       {16'd0, vecs[i].e_ir});
         chk($sformatf("v%0d ir_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].e_vld});
         chk($sformatf("v%0d busy", i),     {31'd0, busy},     {31'd0, vecs[i].e_busy});
         chk($sformatf("v%0d err", i),      {31'd0, err},      {31'd0, vecs[i].e_err});
         chk($sformatf("v%0d z", i),        {31'd0, z},        {31'd0, vecs[i].e_z});
      end

      // Timeout: memory never answers a fetch at PC=2.
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      chk("to_addr", {16'd0, mem_addr}, 32'h0000_0002);
      hi_cnt = 0;
      for (int c = 0; c < 40 && mem_req === 1'b1; c++) begin
         hi_cnt++;
         step();
      end
      chk("to_req_cycles", hi_cnt, 32'd15);
      chk("to_IR_nop",     {16'd0, IR}, 32'h0000_0000);
      chk("to_ir_valid",   {31'd0, ir_valid}, 32'd1);
      chk("to_err",        {31'd0, err}, 32'd1);
      chk("to_busy",       {31'd0, busy}, 32'd0);

      // Good fetch after timeout: PC unchanged, err sticky.
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      chk("post_to_addr", {16'd0, mem_addr}, 32'h0000_0002);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
      step();
      chk("post_to_IR",  {16'd0, IR}, 32'h0000_4444);
      chk("post_to_err", {31'd0, err}, 32'd1);

      // Reset in the middle of a fetch, then a late ready.
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      chk("rst_req",  {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err",  {31'd0, err}, 32'd0);
      chk("rst_IR",   {16'd0, IR}, 32'h0000_0000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5A5A);
      for (int c = 0; c < 2; c++) begin
         step();
         chk($sformatf("late_rdy%0d ir_valid", c), {31'd0, ir_valid}, 32'd0);
         chk($sformatf("late_rdy%0d IR", c),       {16'd0, IR}, 32'h0000_0000);
         chk($sformatf("late_rdy%0d req", c),      {31'd0, mem_req}, 32'd0);
      end
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      step();
      chk("rst_pc_addr", {16'd0, mem_addr}, 32'h0000_0000);
      chk("rst_pc_req",  {31'd0, mem_req}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
